// File: rtl/shift_pkg.sv
// Shared types for the load/shift register and its auto-shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        SM_LSR = 2'b00,
        SM_ASR = 2'b01,
        SM_LSL = 2'b10,
        SM_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// One shift step of a WIDTH-bit word: next value and the bit that leaves.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] D,
    input  shift_mode_t      Mode,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] D_Next,
    output logic             Shift_Out
);

    // Next-word selection for the four shift flavours
    always_comb begin
        D_Next = D;
        case (Mode)
            SM_LSR:  D_Next = {Shift_In, D[WIDTH-1:1]};
            SM_ASR:  D_Next = {D[WIDTH-1], D[WIDTH-1:1]};
            SM_LSL:  D_Next = {D[WIDTH-2:0], Shift_In};
            SM_ROR:  D_Next = {D[0], D[WIDTH-1:1]};
            default: D_Next = D;
        endcase
    end

    // Leaving bit: MSB for left shifts, LSB for everything else
    always_comb begin
        Shift_Out = (Mode == SM_LSL) ? D[WIDTH-1] : D[0];
    end

endmodule

// File: rtl/shift_reg_seq.sv
// WIDTH-bit load/shift register with single-step shifting and an
// auto-sequencer that performs N shifts per Start with a Busy/Done handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting; Start launches a sequence, Shift_En single-steps
//   S_SHIFT | one shift per edge with latched mode, rem_q counts down
//   S_DONE  | one-cycle Done pulse, then back to S_IDLE
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic [1:0]       Mode,
    input  logic             Start,
    input  logic [CNT_W-1:0] Shift_Count,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_d;
    seq_state_t       state_q;
    shift_mode_t      mode_q;
    shift_mode_t      step_mode;
    logic [CNT_W-1:0] rem_q;

    // While a sequence runs the latched mode drives the shared shifter
    always_comb begin
        step_mode = (state_q == S_SHIFT) ? mode_q : shift_mode_t'(Mode);
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .D         (data_q),
        .Mode      (step_mode),
        .Shift_In  (Shift_In),
        .D_Next    (step_d),
        .Shift_Out (Shift_Out)
    );

    // Register, sequencer state and down-counter; Clear > Load > sequencer > Shift_En
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q  <= '0;
            state_q <= S_IDLE;
            mode_q  <= SM_LSR;
            rem_q   <= '0;
        end else if (Clear) begin
            data_q  <= '0;
            state_q <= S_IDLE;
            mode_q  <= SM_LSR;
            rem_q   <= '0;
        end else if (Load) begin
            data_q  <= Data_In;
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        mode_q  <= shift_mode_t'(Mode);
                        rem_q   <= Shift_Count;
                        state_q <= (Shift_Count == '0) ? S_DONE : S_SHIFT;
                    end else if (Shift_En) begin
                        data_q <= step_d;
                    end
                end
                S_SHIFT: begin
                    data_q <= step_d;
                    rem_q  <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the registered state
    always_comb begin
        Data_Out = data_q;
        Busy     = (state_q == S_SHIFT);
        Done     = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed scenarios plus random
// stimulus, all compared against a behavioural model of the register.
module tb_shift_reg_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Clear, Load, Shift_En, Shift_In, Start;
    logic [W-1:0]  Data_In;
    logic [1:0]    Mode;
    logic [CW-1:0] Shift_Count;
    logic [W-1:0]  Data_Out;
    logic          Shift_Out, Busy, Done;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: register value, shifts still owed, Done pending
    logic [W-1:0] m_data;
    int           m_left;
    bit           m_done;
    logic [1:0]   m_lat;

    shift_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Clear       (Clear),
        .Load        (Load),
        .Data_In     (Data_In),
        .Shift_En    (Shift_En),
        .Shift_In    (Shift_In),
        .Mode        (Mode),
        .Start       (Start),
        .Shift_Count (Shift_Count),
        .Data_Out    (Data_Out),
        .Shift_Out   (Shift_Out),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] md, input logic sin);
        int v;
        int msb;
        v   = int'(d);
        msb = 1 << (W - 1);
        case (md)
            2'd0:    v = (v / 2) + (sin ? msb : 0);
            2'd1:    v = (v / 2) + (v & msb);
            2'd2:    v = ((v * 2) + int'(sin)) % (1 << W);
            default: v = (v / 2) + ((v % 2) * msb);
        endcase
        return W'(v);
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_left = 0;
        m_done = 0;
        m_lat  = 2'd0;
    endtask

    // model reaction to one clock edge with the currently driven inputs
    task automatic model_edge();
        if (Clear) begin
            m_data = '0; m_left = 0; m_done = 0; m_lat = 2'd0;
        end else if (Load) begin
            m_data = Data_In; m_left = 0; m_done = 0;
        end else if (m_left > 0) begin
            m_data = ref_shift(m_data, m_lat, Shift_In);
            m_left--;
            m_done = (m_left == 0);
        end else if (m_done) begin
            m_done = 0;
        end else if (Start) begin
            m_lat  = Mode;
            m_left = int'(Shift_Count);
            m_done = (Shift_Count == 0);
        end else if (Shift_En) begin
            m_data = ref_shift(m_data, Mode, Shift_In);
        end
    endtask

    task automatic check_outs();
        logic [1:0] md;
        logic       exp_so;
        md     = (m_left > 0) ? m_lat : Mode;
        exp_so = (md == 2'd2) ? m_data[W-1] : m_data[0];
        chk("data_out", 32'(Data_Out), 32'(m_data));
        chk("busy", 32'(Busy), 32'(m_left > 0));
        chk("done", 32'(Done), 32'(m_done));
        chk("shift_out", 32'(Shift_Out), 32'(exp_so));
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
        check_outs();
    endtask

    task automatic load_val(input logic [W-1:0] v);
        Load = 1'b1; Data_In = v;
        tick();
        Load = 1'b0;
    endtask

    // Start a sequence and measure edges from Start to Done
    task automatic run_seq(input string tag, input logic [1:0] md, input logic sin,
                           input int n, input bit hold, input bit flip_mode);
        int cnt;
        Mode = md; Shift_In = sin; Shift_Count = CW'(n); Start = 1'b1;
        tick();
        cnt = 1;
        Start = hold; Shift_En = hold;
        if (flip_mode) Mode = 2'd0;
        while (!Done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'(n + 1));
        tick();
        Start = 1'b0; Shift_En = 1'b0;
        chk({tag, "_idle"}, 32'(Busy | Done), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0; Clear = 0; Load = 0; Shift_En = 0; Shift_In = 0;
        Start = 0; Data_In = '0; Mode = 2'd0; Shift_Count = '0;
        model_reset();
        #12;
        check_outs();
        Reset_n = 1'b1;

        load_val(8'hB4);
        run_seq("lsr3", 2'd0, 1'b0, 3, 0, 0);
        chk("lsr3_val", 32'(Data_Out), 32'h16);

        load_val(8'h96);
        run_seq("asr2", 2'd1, 1'b0, 2, 0, 0);
        chk("asr2_val", 32'(Data_Out), 32'hE5);

        load_val(8'h81);
        run_seq("ror1", 2'd3, 1'b1, 1, 0, 0);
        chk("ror1_val", 32'(Data_Out), 32'hC0);
        Mode = 2'd3; #1;
        chk("ror1_so", 32'(Shift_Out), 32'd0);

        load_val(8'h81);
        run_seq("lsl4", 2'd2, 1'b1, 4, 0, 1);
        chk("lsl4_val", 32'(Data_Out), 32'h1F);

        run_seq("cnt0", 2'd0, 1'b0, 0, 1, 0);
        chk("cnt0_val", 32'(Data_Out), 32'h1F);

        load_val(8'h5A);
        run_seq("hold", 2'd3, 1'b0, 3, 1, 0);
        chk("hold_val", 32'(Data_Out), 32'h4B);

        run_seq("big", 2'd3, 1'b0, 11, 0, 0);

        // abort by Load on the third shift edge
        load_val(8'hFF);
        Mode = 2'd0; Shift_Count = CW'(5); Start = 1'b1;
        tick(); Start = 1'b0;
        tick(); tick();
        Load = 1'b1; Data_In = 8'h3C;
        tick(); Load = 1'b0;
        chk("abort_load_val", 32'(Data_Out), 32'h3C);
        chk("abort_load_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();

        // abort by Clear
        Shift_Count = CW'(5); Start = 1'b1;
        tick(); Start = 1'b0;
        tick(); tick();
        Clear = 1'b1;
        tick(); Clear = 1'b0;
        chk("abort_clr_val", 32'(Data_Out), 32'h00);
        for (int i = 0; i < 6; i++) tick();

        load_val(8'hA5);
        Clear = 1'b1; Load = 1'b1; Data_In = 8'h77;
        tick(); Clear = 1'b0; Load = 1'b0;
        chk("clr_load_val", 32'(Data_Out), 32'h00);

        // asynchronous reset between edges, mid-sequence
        load_val(8'hC3);
        Mode = 2'd3; Shift_Count = CW'(6); Start = 1'b1;
        tick(); Start = 1'b0;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_data", 32'(Data_Out), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        #1 Reset_n = 1'b1;
        Mode = 2'd2; Shift_In = 1'b1; Shift_En = 1'b1;
        tick(); tick();
        Shift_En = 1'b0;
        chk("rst_lsl_val", 32'(Data_Out), 32'h03);

        // random stimulus
        for (int i = 0; i < 400; i++) begin
            Clear       = ($urandom_range(0, 31) == 0);
            Load        = ($urandom_range(0, 15) == 0);
            Data_In     = W'($urandom);
            Shift_En    = $urandom_range(0, 1) == 1;
            Shift_In    = $urandom_range(0, 1) == 1;
            Mode        = 2'($urandom);
            Start       = ($urandom_range(0, 3) == 0);
            Shift_Count = CW'($urandom_range(0, 10));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
